// File: rtl/dct_mac_accum.sv
// rtl/dct_mac_accum.sv - accumulate N_TAPS products, round, scale and narrow one DCT term
// Define DCT_MAC_SAT_EN to clamp the narrowed result and drive a sticky sat_flag.
module dct_mac_accum #(
  parameter int PROD_W = 29,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int N_TAPS = 8,
  parameter int SHIFT  = 13
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              clr,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_idx,
  output logic              busy,
  output logic              sat_flag
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ACC_W:0]   HALF     = {{(ACC_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    tap_cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    prod_sext;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W:0]      rnd;
  logic [ACC_W-SHIFT:0] r;
  logic [OUT_W-1:0]    narrowed;
  logic                beat;
  logic                last_tap;
  logic                final_beat;
  logic                consume;

  assign prod_sext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign sum       = acc + prod_sext;
  // One guard bit keeps the rounding add from overflowing; dropping the low
  // SHIFT bits of a two's-complement value is a floor, so this is round-half-up.
  assign rnd       = {sum[ACC_W-1], sum} + HALF;
  assign r         = rnd[ACC_W:SHIFT];

  assign last_tap   = (tap_cnt == CNT_LAST);
  assign prod_ready = !(last_tap && out_valid && !out_ready);
  assign beat       = prod_valid && prod_ready;
  assign final_beat = beat && last_tap && !clr;
  assign consume    = out_valid && out_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = (state == ACC);
    if (clr) begin
      next_state = IDLE;
    end else if (beat) begin
      case (state)
        IDLE:    next_state = ACC;
        ACC:     if (last_tap) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc     <= '0;
      tap_cnt <= '0;
    end else if (clr) begin
      acc     <= '0;
      tap_cnt <= '0;
    end else if (beat) begin
      if (state == IDLE) begin
        acc     <= prod_sext;
        tap_cnt <= CNT_ONE;
      end else if (last_tap) begin
        acc     <= '0;
        tap_cnt <= '0;
      end else begin
        acc     <= sum;
        tap_cnt <= tap_cnt + CNT_ONE;
      end
    end
  end

  // A final beat may land in the same cycle the held result is consumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      if (consume) begin
        out_idx <= out_idx + 3'd1;
      end
      if (final_beat) begin
        out_data  <= narrowed;
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DCT_MAC_SAT_EN
  logic ovf_hi;
  logic ovf_lo;
  logic unused_bits;

  assign ovf_hi      = !r[ACC_W-SHIFT] && (|r[ACC_W-SHIFT-1:OUT_W-1]);
  assign ovf_lo      = r[ACC_W-SHIFT] && !(&r[ACC_W-SHIFT-1:OUT_W-1]);
  assign unused_bits = ^rnd[SHIFT-1:0];

  always_comb begin
    narrowed = r[OUT_W-1:0];
    if (ovf_hi) begin
      narrowed = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (ovf_lo) begin
      narrowed = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_flag <= 1'b0;
    end else if (final_beat && (ovf_hi || ovf_lo)) begin
      sat_flag <= 1'b1;
    end
  end
`else
  logic unused_bits;

  assign narrowed    = r[OUT_W-1:0];
  assign sat_flag    = 1'b0;
  assign unused_bits = ^{rnd[SHIFT-1:0], r[ACC_W-SHIFT:OUT_W]};
`endif

endmodule

// File: tb/tb_dct_mac_accum.sv
// tb/tb_dct_mac_accum.sv - directed vector bench for dct_mac_accum
module tb_dct_mac_accum;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        clr;
  logic [28:0] prod_data;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_idx;
  logic        busy;
  logic        sat_flag;

  int n_pass  = 0;
  int n_total = 0;
  int exp_idx = 0;

  typedef struct {
    int          val;
    logic [15:0] exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[9];

  dct_mac_accum dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .clr        (clr),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_beat(input int v);
    int n;
    n = 0;
    prod_data  = v[28:0];
    prod_valid = 1'b1;
    #1;
    while (!prod_ready && n < 50) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    if (!prod_ready) begin
      check("beat_timeout", {31'd0, prod_ready}, 32'd1);
    end else begin
      @(negedge ap_clk);
    end
    prod_valid = 1'b0;
  endtask

  task automatic burst(input int count, input int v);
    for (int k = 0; k < count; k++) send_beat(v);
  endtask

  task automatic pulse_reset();
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  initial begin
    ap_rst_n   = 1'b0;
    clr        = 1'b0;
    prod_data  = '0;
    prod_valid = 1'b0;
    out_ready  = 1'b1;

    vecs[0] = '{4096,       16'h0004, 1'b0};
    vecs[1] = '{-4096,      16'hFFFC, 1'b0};
    vecs[2] = '{8192,       16'h0008, 1'b0};
    vecs[3] = '{1,          16'h0000, 1'b0};
    vecs[4] = '{-1,         16'h0000, 1'b0};
    vecs[5] = '{1024,       16'h0001, 1'b0};
    vecs[6] = '{-1024,      16'hFFFF, 1'b0};
`ifdef DCT_MAC_SAT_EN
    vecs[7] = '{268435455,  16'h7FFF, 1'b1};
    vecs[8] = '{-268435456, 16'h8000, 1'b1};
`else
    vecs[7] = '{268435455,  16'h0000, 1'b0};
    vecs[8] = '{-268435456, 16'h0000, 1'b0};
`endif

    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_idx",   {29'd0, out_idx},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_sat_flag",  {31'd0, sat_flag},  32'd0);
    check("rst_prod_ready",{31'd0, prod_ready},32'd1);

    for (int i = 0; i < 9; i++) begin
      burst(8, vecs[i].val);
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_data", i),  {16'd0, out_data},  {16'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_sat", i),   {31'd0, sat_flag},  {31'd0, vecs[i].exp_sat});
      check($sformatf("vec%0d_idx_pre", i), {29'd0, out_idx}, exp_idx);
      check($sformatf("vec%0d_busy", i),  {31'd0, busy},      32'd0);
      @(negedge ap_clk);
      exp_idx = (exp_idx + 1) % 8;
      check($sformatf("vec%0d_idx_post", i), {29'd0, out_idx}, exp_idx);
      check($sformatf("vec%0d_consumed", i), {31'd0, out_valid}, 32'd0);
    end

    pulse_reset();
    out_ready = 1'b0;
    burst(8, 4096);
    burst(7, 8192);
    check("bp_first_valid", {31'd0, out_valid}, 32'd1);
    check("bp_first_data",  {16'd0, out_data},  32'd4);
    check("bp_busy",        {31'd0, busy},      32'd1);
    prod_data  = 29'd8192;
    prod_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_stall%0d_ready", k), {31'd0, prod_ready}, 32'd0);
      check($sformatf("bp_stall%0d_data", k),  {16'd0, out_data},   32'd4);
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, prod_ready}, 32'd1);
    @(negedge ap_clk);
    prod_valid = 1'b0;
    check("bp_second_valid", {31'd0, out_valid}, 32'd1);
    check("bp_second_data",  {16'd0, out_data},  32'd8);
    check("bp_second_idx",   {29'd0, out_idx},   32'd1);
    check("bp_second_busy",  {31'd0, busy},      32'd0);
    @(negedge ap_clk);
    check("bp_end_valid", {31'd0, out_valid}, 32'd0);
    check("bp_end_idx",   {29'd0, out_idx},   32'd2);

    burst(3, 12345);
    check("clr_pre_busy", {31'd0, busy}, 32'd1);
    clr        = 1'b1;
    prod_data  = 29'd999999;
    prod_valid = 1'b1;
    @(negedge ap_clk);
    clr        = 1'b0;
    prod_valid = 1'b0;
    check("clr_busy",  {31'd0, busy},      32'd0);
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    check("clr_idx",   {29'd0, out_idx},   32'd2);
    burst(8, 8192);
    check("clr_result_valid", {31'd0, out_valid}, 32'd1);
    check("clr_result_data",  {16'd0, out_data},  32'd8);
    @(negedge ap_clk);
    check("clr_result_idx", {29'd0, out_idx}, 32'd3);

    out_ready = 1'b0;
    burst(8, 4096);
    check("arst_held_valid", {31'd0, out_valid}, 32'd1);
    burst(5, 4096);
    check("arst_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data",  {16'd0, out_data},  32'd0);
    check("arst_out_idx",   {29'd0, out_idx},   32'd0);
    check("arst_busy",      {31'd0, busy},      32'd0);
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    out_ready = 1'b1;
    @(negedge ap_clk);
    burst(8, 4096);
    check("arst_fresh_valid", {31'd0, out_valid}, 32'd1);
    check("arst_fresh_data",  {16'd0, out_data},  32'd4);
    check("arst_fresh_idx",   {29'd0, out_idx},   32'd0);
    @(negedge ap_clk);
    check("arst_fresh_idx_post", {29'd0, out_idx}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
